// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART loopback transmit path.
//   DATA_W    default byte width
//   state_e   transmit scheduler states; CRLF exists only when
//             UART_TX_FIFO_CRLF_EN is defined
//   CHAR_CR / CHAR_LF  line-ending characters
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
`ifdef UART_TX_FIFO_CRLF_EN
    ,
    CRLF    = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: circular FIFO storage with pointer and occupancy tracking.
//   clk_i      clock, rising edge
//   rst_ni     synchronous active-low reset (pointers/count only)
//   wr_en_i    write request; ignored when full at the start of the cycle
//   wr_data_i  byte to store
//   rd_en_i    pop request; ignored when empty
//   rd_data_o  entry at the read pointer (no fall-through from the write port)
//   count_o    occupancy 0..DEPTH
//   full_o     count_o == DEPTH
//   empty_o    count_o == 0
module uart_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_acc, rd_acc;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign wr_acc = wr_en_i & ~full_o;
  assign rd_acc = rd_en_i & ~empty_o;

  // Pointers are exactly ADDR_W bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale contents are never visible because
  // the count gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte buffer and transmit scheduler between uart_rx and uart_tx.
//   sys_clk     system clock, rising edge
//   sys_rst_n   synchronous active-low reset
//   rx_data     received byte, valid with rx_done
//   rx_done     one-cycle receive strobe
//   tx_busy     high while uart_tx shifts a frame
//   tx_data     byte presented to uart_tx, stable from LOAD until IDLE
//   tx_start    one-cycle send request
//   fifo_count  occupancy 0..DEPTH
//   fifo_empty  fifo_count == 0
//   fifo_full   fifo_count == DEPTH
//   overflow    sticky: a byte was dropped on a full FIFO
// Optional: define UART_TX_FIFO_CRLF_EN to follow every transmitted CR with
// an inserted LF that consumes no FIFO entry.
module uart_tx_fifo #(
  parameter int unsigned DATA_W = uart_pkg::DATA_W,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              overflow
);

  import uart_pkg::*;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] rd_data;
  logic              pop;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .wr_en_i   (rx_done),
    .wr_data_i (rx_data),
    .rd_en_i   (pop),
    .rd_data_o (rd_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign overflow_d = overflow_q | (rx_done & fifo_full);

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    tx_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy) state_d = LOAD;
      end
      LOAD: begin
        tx_data_d = rd_data;
        pop       = 1'b1;
        state_d   = START;
      end
      START: begin
        tx_start = 1'b1;
        state_d  = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
`ifdef UART_TX_FIFO_CRLF_EN
          // tx_data_q still holds the byte just completed; the inserted LF
          // is not CR, so the second pass through here returns to IDLE.
          state_d = (tx_data_q == DATA_W'(CHAR_CR)) ? CRLF : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef UART_TX_FIFO_CRLF_EN
      CRLF: begin
        tx_data_d = DATA_W'(CHAR_LF);
        state_d   = START;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

endmodule
